// File: rtl/box_overlay_ctrl.sv
// Screen-state controller for the box overlay layer: START/PLAY/PAUSE/GAMEOVER
// sequencing, start-box blink timer, popup cursor and registered pixel compositing.
module box_overlay_ctrl #(
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] GREY_RGB     = 12'h555
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic        btn_start_in,
    input  logic        btn_pause_in,
    input  logic        btn_up_in,
    input  logic        btn_down_in,
    input  logic        btn_select_in,
    input  logic        game_over_in,
    input  logic [11:0] start_box_pixel,
    input  logic [11:0] start_blink_box_pixel,
    input  logic [11:0] grid_outline_pixel,
    input  logic [11:0] score_box_pixel,
    input  logic [11:0] score_divider_pixel,
    input  logic [11:0] next_outer_box_pixel,
    input  logic [11:0] next_inner_box_pixel,
    input  logic [11:0] hold_outer_box_pixel,
    input  logic [11:0] hold_inner_box_pixel,
    input  logic [11:0] popup_box_pixel,
    input  logic [11:0] popup_solid_box_pixel,
    input  logic [11:0] option1_box_pixel,
    input  logic [11:0] option1_select_box_pixel,
    input  logic [11:0] option2_box_pixel,
    input  logic [11:0] option2_select_box_pixel,
    output logic [11:0] box_pixel_out,
    output logic [1:0]  state_out,
    output logic        cursor_out,
    output logic        new_game_out,
    output logic        paused_out
);

    localparam int             CW         = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0]  BLINK_LAST = CW'(BLINK_FRAMES - 1);

    // GREY_RGB is a documentation reference; it must still be a visible colour.
    if (BLINK_FRAMES < 2 || GREY_RGB == 12'h000) begin : g_param_check
        $error("box_overlay_ctrl: BLINK_FRAMES must be >= 2 and GREY_RGB non-zero");
    end

    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_PAUSE    = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          cursor_q, cursor_d;
    logic          new_game_d;
    logic [CW-1:0] blink_cnt_q;
    logic          blink_phase_q;
    logic [4:0]    btn_q;
    logic [4:0]    btn_now;
    logic [4:0]    btn_edge;
    logic          start_e, pause_e, up_e, down_e, select_e;
    logic [11:0]   play_layer;
    logic [11:0]   pixel_d;

    assign btn_now  = {btn_select_in, btn_down_in, btn_up_in, btn_pause_in, btn_start_in};
    assign btn_edge = btn_now & ~btn_q;
    assign {select_e, down_e, up_e, pause_e, start_e} = btn_edge;

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned -- a missing default here would infer a latch.
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        new_game_d = 1'b0;
        case (state_q)
            ST_START: begin
                if (start_e) begin
                    state_d    = ST_PLAY;
                    new_game_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (game_over_in) begin
                    state_d  = ST_GAMEOVER;
                    cursor_d = 1'b0;
                end else if (pause_e) begin
                    state_d  = ST_PAUSE;
                    cursor_d = 1'b0;
                end
            end
            ST_PAUSE: begin
                if (pause_e) begin
                    state_d = ST_PLAY;
                end else if (select_e) begin
                    state_d = cursor_q ? ST_START : ST_PLAY;
                end else if (up_e ^ down_e) begin
                    cursor_d = down_e;
                end
            end
            ST_GAMEOVER: begin
                // A select acts on the cursor it sees, so a same-cycle move is dropped.
                if (select_e) begin
                    state_d    = cursor_q ? ST_START : ST_PLAY;
                    new_game_d = ~cursor_q;
                end else if (up_e ^ down_e) begin
                    cursor_d = down_e;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_START;
            cursor_q     <= 1'b0;
            new_game_out <= 1'b0;
            btn_q        <= '0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            new_game_out <= new_game_d;
            btn_q        <= btn_now;
        end
    end

    // Blink timer runs only while START is shown and restarts on every entry.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (state_q != ST_START && state_d == ST_START) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (state_q == ST_START && new_frame_in) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + CW'(1);
            end
        end
    end

    assign play_layer = grid_outline_pixel | score_box_pixel | score_divider_pixel |
                        next_outer_box_pixel | next_inner_box_pixel |
                        hold_outer_box_pixel | hold_inner_box_pixel;

    always_comb begin
        pixel_d = play_layer;
        case (state_q)
            ST_START: pixel_d = blink_phase_q ? start_blink_box_pixel : start_box_pixel;
            ST_PLAY:  pixel_d = play_layer;
            default: begin
                if (popup_box_pixel != 12'h000)
                    pixel_d = popup_box_pixel;
                else if ((cursor_q ? option2_select_box_pixel : option1_select_box_pixel) != 12'h000)
                    pixel_d = cursor_q ? option2_select_box_pixel : option1_select_box_pixel;
                else if ((cursor_q ? option1_box_pixel : option2_box_pixel) != 12'h000)
                    pixel_d = cursor_q ? option1_box_pixel : option2_box_pixel;
                else if (popup_solid_box_pixel != 12'h000)
                    pixel_d = popup_solid_box_pixel;
                else
                    pixel_d = play_layer;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) box_pixel_out <= 12'h000;
        else        box_pixel_out <= pixel_d;
    end

    assign state_out  = state_q;
    assign cursor_out = cursor_q;
    assign paused_out = (state_q == ST_PAUSE) || (state_q == ST_GAMEOVER);

endmodule

// File: tb/tb_box_overlay_ctrl.sv
// Directed bench for box_overlay_ctrl: state sequencing, cursor, blink timing,
// pixel priority and reset behaviour, checked with immediate assertions.
module tb_box_overlay_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        new_frame_in, btn_start_in, btn_pause_in, btn_up_in, btn_down_in;
    logic        btn_select_in, game_over_in;
    logic [11:0] start_box_pixel, start_blink_box_pixel, grid_outline_pixel;
    logic [11:0] score_box_pixel, score_divider_pixel, next_outer_box_pixel;
    logic [11:0] next_inner_box_pixel, hold_outer_box_pixel, hold_inner_box_pixel;
    logic [11:0] popup_box_pixel, popup_solid_box_pixel, option1_box_pixel;
    logic [11:0] option1_select_box_pixel, option2_box_pixel, option2_select_box_pixel;
    logic [11:0] box_pixel_out;
    logic [1:0]  state_out;
    logic        cursor_out, new_game_out, paused_out;

    int checks = 0;
    int errors = 0;

    box_overlay_ctrl #(.BLINK_FRAMES(4), .GREY_RGB(12'h555)) dut (
        .clk_in                   (clk_in),
        .rst_in                   (rst_in),
        .new_frame_in             (new_frame_in),
        .btn_start_in             (btn_start_in),
        .btn_pause_in             (btn_pause_in),
        .btn_up_in                (btn_up_in),
        .btn_down_in              (btn_down_in),
        .btn_select_in            (btn_select_in),
        .game_over_in             (game_over_in),
        .start_box_pixel          (start_box_pixel),
        .start_blink_box_pixel    (start_blink_box_pixel),
        .grid_outline_pixel       (grid_outline_pixel),
        .score_box_pixel          (score_box_pixel),
        .score_divider_pixel      (score_divider_pixel),
        .next_outer_box_pixel     (next_outer_box_pixel),
        .next_inner_box_pixel     (next_inner_box_pixel),
        .hold_outer_box_pixel     (hold_outer_box_pixel),
        .hold_inner_box_pixel     (hold_inner_box_pixel),
        .popup_box_pixel          (popup_box_pixel),
        .popup_solid_box_pixel    (popup_solid_box_pixel),
        .option1_box_pixel        (option1_box_pixel),
        .option1_select_box_pixel (option1_select_box_pixel),
        .option2_box_pixel        (option2_box_pixel),
        .option2_select_box_pixel (option2_select_box_pixel),
        .box_pixel_out            (box_pixel_out),
        .state_out                (state_out),
        .cursor_out               (cursor_out),
        .new_game_out             (new_game_out),
        .paused_out               (paused_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int         transitions;
        int         ng_count;
        logic [1:0] prev_state;

        rst_in = 1'b1;
        {new_frame_in, btn_start_in, btn_pause_in, btn_up_in, btn_down_in,
         btn_select_in, game_over_in} = '0;
        start_box_pixel = 12'h555;  start_blink_box_pixel = 12'hFFF;
        {grid_outline_pixel, score_box_pixel, score_divider_pixel, next_outer_box_pixel,
         next_inner_box_pixel, hold_outer_box_pixel, hold_inner_box_pixel, popup_box_pixel,
         popup_solid_box_pixel, option1_box_pixel, option1_select_box_pixel,
         option2_box_pixel, option2_select_box_pixel} = '0;

        // Reset state
        repeat (3) step();
        check("rst_state", 12'(state_out), 12'd0);
        check("rst_cursor", 12'(cursor_out), 12'd0);
        check("rst_pixel", box_pixel_out, 12'h000);
        check("rst_new_game", 12'(new_game_out), 12'd0);
        check("rst_paused", 12'(paused_out), 12'd0);
        rst_in = 1'b0;

        // Blink: starts on the blink box, toggles every 4 frames
        step();
        check("blink_init", box_pixel_out, 12'hFFF);
        for (int k = 1; k <= 16; k++) begin
            new_frame_in = 1'b1;
            step();
            new_frame_in = 1'b0;
            step();
            check($sformatf("blink_frame%0d", k), box_pixel_out,
                  (((k / 4) % 2) == 0) ? 12'hFFF : 12'h555);
        end
        check("blink_still_start", 12'(state_out), 12'd0);

        // START -> PLAY with one new_game pulse even while start is held
        btn_start_in = 1'b1;
        step();
        check("start_to_play", 12'(state_out), 12'd1);
        check("new_game_pulse", 12'(new_game_out), 12'd1);
        step();
        check("new_game_one_cycle", 12'(new_game_out), 12'd0);
        btn_start_in = 1'b0;

        // PLAY layer is the OR of its sources
        grid_outline_pixel = 12'h100; score_box_pixel = 12'h020; hold_inner_box_pixel = 12'h003;
        step();
        check("play_or", box_pixel_out, 12'h123);
        {grid_outline_pixel, score_box_pixel, hold_inner_box_pixel} = '0;

        // PAUSE and cursor movement
        btn_pause_in = 1'b1;
        step();
        check("pause_state", 12'(state_out), 12'd2);
        check("pause_paused", 12'(paused_out), 12'd1);
        check("pause_cursor", 12'(cursor_out), 12'd0);
        btn_pause_in = 1'b0;  step();
        btn_down_in = 1'b1;   step();
        check("down_cursor1", 12'(cursor_out), 12'd1);
        btn_down_in = 1'b0;   step();
        btn_down_in = 1'b1;   step();
        check("down_saturate", 12'(cursor_out), 12'd1);
        btn_down_in = 1'b0;   step();
        {btn_up_in, btn_down_in} = 2'b11;
        step();
        check("up_down_hold", 12'(cursor_out), 12'd1);
        {btn_up_in, btn_down_in} = 2'b00;
        step();
        btn_select_in = 1'b1;
        step();
        check("select_to_start", 12'(state_out), 12'd0);
        check("select_no_new_game", 12'(new_game_out), 12'd0);
        btn_select_in = 1'b0;
        step();
        check("start_no_new_game", 12'(new_game_out), 12'd0);

        // Back to PLAY, then game over beats a same-cycle pause
        btn_start_in = 1'b1;  step();
        btn_start_in = 1'b0;  step();
        game_over_in = 1'b1;  btn_pause_in = 1'b1;
        step();
        check("gameover_priority", 12'(state_out), 12'd3);
        check("gameover_cursor", 12'(cursor_out), 12'd0);
        check("gameover_paused", 12'(paused_out), 12'd1);
        game_over_in = 1'b0;  btn_pause_in = 1'b0;
        step();
        btn_pause_in = 1'b1;  step();
        check("gameover_ignores_pause", 12'(state_out), 12'd3);
        btn_pause_in = 1'b0;  step();
        btn_select_in = 1'b1;
        step();
        check("gameover_to_play", 12'(state_out), 12'd1);
        check("gameover_new_game", 12'(new_game_out), 12'd1);
        btn_select_in = 1'b0;
        step();
        check("gameover_new_game_end", 12'(new_game_out), 12'd0);

        // PAUSE pixel priority, cursor 0
        btn_pause_in = 1'b1;  step();
        btn_pause_in = 1'b0;  step();
        popup_box_pixel = 12'h555;  option1_select_box_pixel = 12'hFFF;
        #1;
        check("pixel_latency", box_pixel_out, 12'h000);
        step();
        check("prio_popup", box_pixel_out, 12'h555);
        popup_box_pixel = 12'h000;  popup_solid_box_pixel = 12'h111;
        step();
        check("prio_selected", box_pixel_out, 12'hFFF);
        option1_select_box_pixel = 12'h000;  popup_solid_box_pixel = 12'h000;
        grid_outline_pixel = 12'h555;
        step();
        check("prio_play_layer", box_pixel_out, 12'h555);
        option2_box_pixel = 12'h0AA;
        step();
        check("prio_unselected", box_pixel_out, 12'h0AA);
        btn_down_in = 1'b1;  step();
        btn_down_in = 1'b0;  step();
        check("prio_cursor1_fallthrough", box_pixel_out, 12'h555);
        {grid_outline_pixel, option2_box_pixel} = '0;

        // Held select gives exactly one transition (cursor back to 0 first)
        btn_up_in = 1'b1;  step();
        btn_up_in = 1'b0;  step();
        check("up_cursor0", 12'(cursor_out), 12'd0);
        transitions = 0;  ng_count = 0;  prev_state = state_out;
        btn_select_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (state_out != prev_state) transitions++;
            if (new_game_out) ng_count++;
            prev_state = state_out;
        end
        btn_select_in = 1'b0;
        check("held_select_transitions", 12'(transitions), 12'd1);
        check("held_select_resume", 12'(state_out), 12'd1);
        check("held_select_no_new_game", 12'(ng_count), 12'd0);
        step();

        // Select with a simultaneous down edge uses cursor 0
        btn_pause_in = 1'b1;  step();
        btn_pause_in = 1'b0;  step();
        btn_select_in = 1'b1;  btn_down_in = 1'b1;
        step();
        check("select_down_resume", 12'(state_out), 12'd1);
        check("select_down_no_new_game", 12'(new_game_out), 12'd0);
        btn_select_in = 1'b0;  btn_down_in = 1'b0;
        step();

        // Asynchronous reset mid-PAUSE with cursor 1
        btn_pause_in = 1'b1;  step();
        btn_pause_in = 1'b0;  step();
        btn_down_in = 1'b1;   step();
        btn_down_in = 1'b0;
        popup_box_pixel = 12'h555;
        step();
        check("pre_reset_cursor", 12'(cursor_out), 12'd1);
        check("pre_reset_pixel", box_pixel_out, 12'h555);
        popup_box_pixel = 12'h000;
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_state", 12'(state_out), 12'd0);
        check("async_rst_cursor", 12'(cursor_out), 12'd0);
        check("async_rst_pixel", box_pixel_out, 12'h000);
        step();
        rst_in = 1'b0;
        step();
        check("post_reset_blink", box_pixel_out, 12'hFFF);
        btn_start_in = 1'b1;
        step();
        check("post_reset_play", 12'(state_out), 12'd1);
        check("post_reset_new_game", 12'(new_game_out), 12'd1);
        btn_start_in = 1'b0;
        step();
        check("post_reset_new_game_end", 12'(new_game_out), 12'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
